// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared widths, id type and round-robin pointer helper for mult_arbiter
package mult_arb_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF = $clog2(NUM_REQ_DEF);
  typedef logic [ID_W_DEF-1:0] id_t;
  function automatic int rr_next(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/mult.sv
// mult: unsigned W x W combinational multiplier with full 2W-bit product
module mult #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  assign p_o = (2*W)'(a_i) * (2*W)'(b_i);
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  // Scan farthest-first so the closest hit to ptr overrides the rest
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = W'((int'(ptr_i) + k) % N);
    any_o = |req_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one 8x8 multiplier among NUM_REQ requesters.
// Define MULT_ARB_OPREG_EN to register granted operands before the multiplier (latency 2).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product
);
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, g_idx, m_id, rsp_id_q;
  logic              any, m_v, rsp_valid_q;
  logic [OP_W-1:0]   g_a, g_b, m_a, m_b;
  logic [PROD_W-1:0] m_p, rsp_product_q;

  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(req_ready),
    .idx_o(g_idx),
    .any_o(any)
  );

  assign g_a = req_a[OP_W*g_idx +: OP_W];
  assign g_b = req_b[OP_W*g_idx +: OP_W];

  // A grant always transfers, since ready is only raised on a valid requester
  always_comb rr_ptr_d = any ? ID_W'(rr_next(int'(g_idx), NUM_REQ)) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;

`ifdef MULT_ARB_OPREG_EN
  logic            op_v_q;
  logic [ID_W-1:0] op_id_q;
  logic [OP_W-1:0] op_a_q, op_b_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_v_q  <= 1'b0;
      op_id_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      op_v_q <= any;
      if (any) begin
        op_id_q <= g_idx;
        op_a_q  <= g_a;
        op_b_q  <= g_b;
      end
    end
  assign m_v  = op_v_q;
  assign m_id = op_id_q;
  assign m_a  = op_a_q;
  assign m_b  = op_b_q;
`else
  assign m_v  = any;
  assign m_id = g_idx;
  assign m_a  = g_a;
  assign m_b  = g_b;
`endif

  mult #(.W(OP_W)) u_mult (
    .a_i(m_a),
    .b_i(m_b),
    .p_o(m_p)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      rsp_valid_q <= m_v;
      if (m_v) begin
        rsp_id_q      <= m_id;
        rsp_product_q <= m_p;
      end
    end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter (both latency builds)
module tb_mult_arbiter;
`ifdef MULT_ARB_OPREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rv = '0;
  logic [3:0]  rdy;
  logic [31:0] ra = '0, rb = '0;
  logic        rsp_v;
  logic [1:0]  rsp_i;
  logic [15:0] rsp_p;
  int          n_chk = 0, n_fail = 0;
  logic        pv[2];
  logic [1:0]  pid[2];
  logic [15:0] pp[2];
  logic [1:0]  last_id = '0;
  logic [15:0] last_p = '0;

  always #5 clk = ~clk;

  mult_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(rv),
    .req_ready(rdy),
    .req_a(ra),
    .req_b(rb),
    .rsp_valid(rsp_v),
    .rsp_id(rsp_i),
    .rsp_product(rsp_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0;
      pid[i] = '0;
      pp[i] = '0;
    end
    last_id = '0;
    last_p = '0;
  endtask

  // One clock: drive requests, check grant, then check response against the expected pipe
  task automatic cyc(input logic [3:0] v, input logic [3:0] er, input logic [15:0] ep, input string tag);
    rv = v;
    #1;
    check({tag, " ready"}, 32'(rdy), 32'(er));
    pv[1] = pv[0];
    pid[1] = pid[0];
    pp[1] = pp[0];
    pv[0] = |er;
    pid[0] = oh2idx(er);
    pp[0] = ep;
    @(posedge clk);
    #1;
    check({tag, " rsp_valid"}, 32'(rsp_v), 32'(pv[LAT-1]));
    if (pv[LAT-1]) begin
      last_id = pid[LAT-1];
      last_p = pp[LAT-1];
    end
    check({tag, " rsp_id"}, 32'(rsp_i), 32'(last_id));
    check({tag, " rsp_product"}, 32'(rsp_p), 32'(last_p));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < LAT; i++) cyc(4'h0, 4'h0, 16'h0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_pipe();
    ra = {8'h04, 8'h03, 8'h02, 8'h01};
    rb = {8'h10, 8'h10, 8'h10, 8'h10};
    #1;
    check("reset rsp_valid", 32'(rsp_v), 32'h0);
    check("reset rsp_product", 32'(rsp_p), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle ready", 32'(rdy), 32'h0);
    // All valid: strict 0,1,2,3 rotation from reset pointer
    cyc(4'hF, 4'h1, 16'h0010, "all0");
    cyc(4'hF, 4'h2, 16'h0020, "all1");
    cyc(4'hF, 4'h4, 16'h0030, "all2");
    cyc(4'hF, 4'h8, 16'h0040, "all3");
    cyc(4'hF, 4'h1, 16'h0010, "all4");
    cyc(4'hF, 4'h2, 16'h0020, "all5");
    drain("drain_all");
    // Single requester 2 at full throughput
    ra[23:16] = 8'h12;
    rb[23:16] = 8'h34;
    for (int i = 0; i < 5; i++) cyc(4'h4, 4'h4, 16'h03A8, "single");
    drain("drain_single");
    // Pointer at 3, only 1 and 3 valid: wrap and skip
    cyc(4'hA, 4'h8, 16'h0040, "wrap0");
    cyc(4'hA, 4'h2, 16'h0020, "wrap1");
    cyc(4'hA, 4'h8, 16'h0040, "wrap2");
    cyc(4'hA, 4'h2, 16'h0020, "wrap3");
    drain("drain_wrap");
    // Product corners through requester 2
    ra[23:16] = 8'hFF;
    rb[23:16] = 8'hFF;
    cyc(4'h4, 4'h4, 16'hFE01, "ffxff");
    ra[23:16] = 8'h00;
    rb[23:16] = 8'hAB;
    cyc(4'h4, 4'h4, 16'h0000, "zero");
    ra[23:16] = 8'h01;
    rb[23:16] = 8'h80;
    cyc(4'h4, 4'h4, 16'h0080, "one");
    drain("drain_corner");
    // Withdraw: req 1 leaves without transfer; pointer moves only on grants
    ra[23:16] = 8'h03;
    rb[23:16] = 8'h10;
    cyc(4'h3, 4'h1, 16'h0010, "wd_grant0");
    cyc(4'h0, 4'h0, 16'h0000, "wd_idle");
    cyc(4'h5, 4'h4, 16'h0030, "wd_grant2");
    cyc(4'h5, 4'h1, 16'h0010, "wd_grant0b");
    drain("drain_wd");
    // Async reset with an operation in flight
    rv = 4'hF;
    #1;
    check("rst_pre ready", 32'(rdy), 32'h2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async rsp_valid", 32'(rsp_v), 32'h0);
    check("rst_async rsp_id", 32'(rsp_i), 32'h0);
    check("rst_async rsp_product", 32'(rsp_p), 32'h0);
    rv = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_pipe();
    check("rst_release rsp_valid", 32'(rsp_v), 32'h0);
    drain("rst_nostale");
    cyc(4'hF, 4'h1, 16'h0010, "rst_first");
    cyc(4'hF, 4'h2, 16'h0020, "rst_second");
    drain("drain_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
